// File: rtl/bus_to_uart_pkg.sv
// Shared sizes, defaults and FSM state type for the bus-to-UART bridge.
package bus_uart_pkg;

  localparam int unsigned ADDR_W         = 14;
  localparam int unsigned DATA_W         = 8;
  localparam int unsigned DATA_START_BIT = 6;

  localparam logic [ADDR_W-1:0] DEF_SLAVE_ADDR  = 14'b01000000000000;
  localparam logic [DATA_W-1:0] DEF_ACK_PATTERN = 8'b11001100;
  localparam logic [9:0]        DEF_ACK_TIMEOUT = 10'd1023;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    CHECK,
    TX_START,
    TX_DATA,
    TX_STOP,
    WAIT_ACK,
    ACK_RX
  } state_t;

endpackage

// File: rtl/uart_byte_tx.sv
// Start / 8 data bits MSB first / stop serialiser with load and busy handshake.
module uart_byte_tx
  import bus_uart_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              tx
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_W + 1);

  logic [DATA_W+1:0] sh_q, sh_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;

  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (load && !busy_q) begin
      sh_d   = {1'b0, din, 1'b1};
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      sh_d  = {sh_q[DATA_W:0], 1'b1};
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == LAST_BIT) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q   <= '1;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  // Line bit is combinational here; the top registers it, giving the one-cycle lag
  assign tx   = busy_q ? sh_q[DATA_W+1] : 1'b1;

endmodule

// File: rtl/bus_to_uart.sv
// Serial bus slave: captures a 14-bit address / 8-bit data frame, forwards the
// byte over a UART line and then waits for an 8-bit acknowledgement byte.
module bus_to_uart
  import bus_uart_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR  = DEF_SLAVE_ADDR,
  parameter logic [9:0]        ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter logic [DATA_W-1:0] ACK_PATTERN = DEF_ACK_PATTERN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_s,
  input  logic              write_en_slave,
  input  logic              addr_rx,
  input  logic              data_rx,
  output logic              data_tx,
  input  logic              ack_in,
  output logic              slave_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              ack_ok,
  output logic              ack_err
);

  state_t              state_q, state_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [9:0]          to_cnt_q, to_cnt_d;
  logic [ADDR_W-1:0]   addr_sr_q, addr_sr_d;
  logic [DATA_W-1:0]   data_sr_q, data_sr_d;
  logic [DATA_W-1:0]   ack_sr_q, ack_sr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                data_tx_q, data_tx_d;
  logic                slave_ready_q, slave_ready_d;
  logic                ack_ok_q, ack_ok_d;
  logic                ack_err_q, ack_err_d;
  logic                tx_load, tx_busy, tx_line;
  logic [DATA_W-1:0]   ack_byte;

  uart_byte_tx u_tx (
    .clk  (clk),
    .reset(reset),
    .load (tx_load),
    .din  (data_sr_q),
    .busy (tx_busy),
    .tx   (tx_line)
  );

  assign ack_byte = {ack_sr_q[DATA_W-2:0], ack_in};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    to_cnt_d   = to_cnt_q;
    addr_sr_d  = addr_sr_q;
    data_sr_d  = data_sr_q;
    ack_sr_d   = ack_sr_q;
    we_d       = we_q;
    data_out_d = data_out_q;
    ack_ok_d   = 1'b0;
    ack_err_d  = 1'b0;
    tx_load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_s && slave_ready_q) begin
          addr_sr_d = {addr_sr_q[ADDR_W-2:0], addr_rx};
          we_d      = write_en_slave;
          bit_cnt_d = 4'd1;
          state_d   = RECV;
        end
      end
      RECV: begin
        // valid_s low just holds everything: a split transfer resumes in place
        if (valid_s) begin
          addr_sr_d = {addr_sr_q[ADDR_W-2:0], addr_rx};
          if (bit_cnt_q >= 4'(DATA_START_BIT)) begin
            data_sr_d = {data_sr_q[DATA_W-2:0], data_rx};
          end
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(ADDR_W - 1)) begin
            bit_cnt_d = '0;
            state_d   = CHECK;
          end
        end
      end
      CHECK: begin
        if (addr_sr_q == SLAVE_ADDR && we_q && !tx_busy) begin
          data_out_d = data_sr_q;
          tx_load    = 1'b1;
          state_d    = TX_START;
        end else begin
          state_d = IDLE;
        end
      end
      TX_START: begin
        bit_cnt_d = '0;
        state_d   = TX_DATA;
      end
      TX_DATA: begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'(DATA_W - 1)) begin
          bit_cnt_d = '0;
          state_d   = TX_STOP;
        end
      end
      TX_STOP: begin
        to_cnt_d = '0;
        state_d  = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!ack_in) begin
          bit_cnt_d = '0;
          state_d   = ACK_RX;
        end else if (to_cnt_q + 10'd1 == ACK_TIMEOUT) begin
          ack_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 10'd1;
        end
      end
      ACK_RX: begin
        ack_sr_d  = ack_byte;
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'(DATA_W - 1)) begin
          bit_cnt_d = '0;
          ack_ok_d  = (ack_byte == ACK_PATTERN);
          ack_err_d = (ack_byte != ACK_PATTERN);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    slave_ready_d = (state_d == IDLE);
    data_tx_d     = tx_line;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      to_cnt_q      <= '0;
      addr_sr_q     <= '0;
      data_sr_q     <= '0;
      ack_sr_q      <= '0;
      we_q          <= 1'b0;
      data_out_q    <= '0;
      data_tx_q     <= 1'b1;
      slave_ready_q <= 1'b1;
      ack_ok_q      <= 1'b0;
      ack_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      to_cnt_q      <= to_cnt_d;
      addr_sr_q     <= addr_sr_d;
      data_sr_q     <= data_sr_d;
      ack_sr_q      <= ack_sr_d;
      we_q          <= we_d;
      data_out_q    <= data_out_d;
      data_tx_q     <= data_tx_d;
      slave_ready_q <= slave_ready_d;
      ack_ok_q      <= ack_ok_d;
      ack_err_q     <= ack_err_d;
    end
  end

  assign data_tx     = data_tx_q;
  assign slave_ready = slave_ready_q;
  assign data_out    = data_out_q;
  assign ack_ok      = ack_ok_q;
  assign ack_err     = ack_err_q;

endmodule

// File: tb/tb_bus_to_uart.sv
// Randomised scoreboard bench for bus_to_uart: stimulus queues expected UART
// frames and ack pulses; independent monitors pop and compare them.
module tb_bus_to_uart;

  localparam logic [13:0] SLV = 14'b01000000000000;
  localparam logic [7:0]  PAT = 8'b11001100;
  localparam logic [9:0]  TMO = 10'd1023;

  logic       clk = 1'b0;
  logic       reset, valid_s, write_en_slave, addr_rx, data_rx, ack_in;
  logic       data_tx, slave_ready, ack_ok, ack_err;
  logic [7:0] data_out;

  bus_to_uart #(.SLAVE_ADDR(SLV), .ACK_TIMEOUT(TMO), .ACK_PATTERN(PAT)) dut (
    .clk           (clk),
    .reset         (reset),
    .valid_s       (valid_s),
    .write_en_slave(write_en_slave),
    .addr_rx       (addr_rx),
    .data_rx       (data_rx),
    .data_tx       (data_tx),
    .ack_in        (ack_in),
    .slave_ready   (slave_ready),
    .data_out      (data_out),
    .ack_ok        (ack_ok),
    .ack_err       (ack_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [7:0] data; int unsigned start; } tx_exp_t;
  typedef struct { bit ok; int unsigned at; } ack_exp_t;
  tx_exp_t  txq[$];
  ack_exp_t ackq[$];
  logic [7:0] last_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // UART line monitor: start bit, 8 data bits MSB first, stop bit
  initial begin : tx_mon
    bit          cap;
    int          idx;
    logic [7:0]  got;
    int unsigned st;
    tx_exp_t     e;
    cap = 0; idx = 0; got = '0; st = 0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (cap) begin
          cap = 0;
          if (txq.size() > 0) void'(txq.pop_front());
        end
      end else if (!cap) begin
        if (data_tx === 1'b0) begin
          cap = 1; st = cyc; idx = 0; got = '0;
        end
      end else if (idx < 8) begin
        got = {got[6:0], data_tx};
        idx++;
      end else begin
        cap = 0;
        chk("tx_stop_bit", 32'(data_tx), 32'd1);
        chk("tx_frame_expected", 32'(txq.size() > 0), 32'd1);
        if (txq.size() > 0) begin
          e = txq.pop_front();
          chk("tx_byte", 32'(got), 32'(e.data));
          chk("tx_start_cycle", st, e.start);
          chk("data_out", 32'(data_out), 32'(e.data));
        end
      end
    end
  end

  initial begin : ack_mon
    ack_exp_t e;
    forever begin
      @(negedge clk);
      if (ack_ok === 1'b1 || ack_err === 1'b1) begin
        chk("ack_exclusive", 32'(ack_ok & ack_err), 32'd0);
        chk("ack_expected", 32'(ackq.size() > 0), 32'd1);
        if (ackq.size() > 0) begin
          e = ackq.pop_front();
          chk("ack_ok_vs_err", 32'(ack_ok), 32'(e.ok));
          chk("ack_cycle", cyc, e.at);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic noise();
    addr_rx        = 1'($urandom_range(0, 1));
    data_rx        = 1'($urandom_range(0, 1));
    write_en_slave = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_cyc(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (slave_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(slave_ready), 32'd1);
  endtask

  task automatic send_frame(input logic [13:0] addr, input logic [7:0] data, input logic we,
                            input int stall, output int unsigned b13edge);
    b13edge = 0;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) chk("ready_low_in_frame", 32'(slave_ready), 32'd0);
      if (i == 9) begin
        for (int s = 0; s < stall; s++) begin
          valid_s = 1'b0;
          noise();
          @(negedge clk);
        end
      end
      valid_s        = 1'b1;
      addr_rx        = addr[13-i];
      data_rx        = (i >= 6) ? data[13-i] : 1'($urandom_range(0, 1));
      write_en_slave = (i == 0) ? we : 1'($urandom_range(0, 1));
      if (i == 13) b13edge = cyc + 1;
    end
    @(negedge clk);
    valid_s = 1'b0;
    noise();
  endtask

  // mode 0: no acknowledgement (timeout); mode 1: drive ack_byte after 'delay' idle cycles
  task automatic run_frame(input logic [13:0] addr, input logic [7:0] data, input logic we,
                           input int stall, input int mode, input logic [7:0] ack_byte,
                           input int unsigned delay);
    int unsigned b13, s, a0;
    wait_ready();
    send_frame(addr, data, we, stall, b13);
    if (addr == SLV && we) begin
      s = b13 + 2;
      txq.push_back('{data: data, start: s});
      last_data = data;
      if (mode == 0) begin
        ackq.push_back('{ok: 1'b0, at: s + 9 + 32'(TMO)});
        wait_cyc(s + 10 + 32'(TMO));
      end else begin
        a0 = s + 10 + delay;
        ackq.push_back('{ok: (ack_byte == PAT), at: a0 + 8});
        wait_cyc(a0 - 1);
        ack_in  = 1'b0;
        valid_s = 1'b1;
        noise();
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          ack_in  = ack_byte[7-k];
          valid_s = 1'($urandom_range(0, 1));
          noise();
        end
        @(negedge clk);
        ack_in  = 1'b1;
        valid_s = 1'b0;
      end
    end else begin
      @(negedge clk);
      chk("ready_after_reject", 32'(slave_ready), 32'd1);
      chk("data_out_hold", 32'(data_out), 32'(last_data));
    end
  endtask

  task automatic reset_mid_tx();
    int unsigned b13, s;
    logic [7:0]  d;
    d = 8'($urandom);
    wait_ready();
    send_frame(SLV, d, 1'b1, 0, b13);
    s = b13 + 2;
    txq.push_back('{data: d, start: s});
    wait_cyc(s + 4);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_tx_data_tx", 32'(data_tx), 32'd1);
    chk("rst_tx_ready", 32'(slave_ready), 32'd1);
    chk("rst_tx_data_out", 32'(data_out), 32'd0);
    chk("rst_tx_no_ack", 32'({ack_ok, ack_err}), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    last_data = '0;
  endtask

  initial begin : stim
    logic [13:0] a;
    logic [7:0]  d, ab;
    logic        we;
    int          st;
    reset = 1'b1; valid_s = 1'b0; ack_in = 1'b1;
    write_en_slave = 1'b0; addr_rx = 1'b0; data_rx = 1'b0;
    last_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_data_tx", 32'(data_tx), 32'd1);
    chk("reset_ready", 32'(slave_ready), 32'd1);
    chk("reset_data_out", 32'(data_out), 32'd0);
    chk("reset_ack_ok", 32'(ack_ok), 32'd0);
    chk("reset_ack_err", 32'(ack_err), 32'd0);
    reset = 1'b0;

    run_frame(SLV, 8'hA5, 1'b1, 0, 1, PAT, 0);
    run_frame(14'h0001, 8'h5A, 1'b1, 0, 1, PAT, 0);
    run_frame(SLV, 8'h3C, 1'b1, 5, 1, 8'b11001101, 2);
    run_frame(SLV, 8'h77, 1'b0, 0, 1, PAT, 0);
    run_frame(SLV, 8'($urandom), 1'b1, 0, 0, PAT, 0);

    for (int n = 0; n < 12; n++) begin
      a  = ($urandom_range(0, 1) == 1) ? SLV : 14'($urandom);
      we = ($urandom_range(0, 3) != 0);
      d  = 8'($urandom);
      ab = ($urandom_range(0, 1) == 1) ? PAT : 8'($urandom);
      st = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0;
      run_frame(a, d, we, st, 1, ab, $urandom_range(0, 4));
    end

    reset_mid_tx();
    run_frame(SLV, 8'hC3, 1'b1, 0, 1, PAT, 1);

    repeat (1100) @(negedge clk);
    chk("tx_queue_drained", txq.size(), 32'd0);
    chk("ack_queue_drained", ackq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_to_uart.md
BUS_TO_UART -- requirements
Module: bus_to_uart

Interface
REQ-001 Parameter: SLAVE_ADDR, 14'b01000000000000, the address this slave responds to.
REQ-002 Parameter: ACK_TIMEOUT, 10'd1023, the number of cycles to wait for an ack start bit.
REQ-003 Parameter: ACK_PATTERN, 8'b11001100, the expected acknowledgement byte.
REQ-004 Port: clk, input, 1, the clock.
REQ-005 Port: reset, input, 1, synchronous active-high reset.
REQ-006 Port: valid_s, input, 1, bus frame valid; bit sampling is enabled while high.
REQ-007 Port: write_en_slave, input, 1, bus write qualifier; 1 means a write to this slave.
REQ-008 Port: addr_rx, input, 1, serial address bit, MSB first.
REQ-009 Port: data_rx, input, 1, serial data bit, MSB first.
REQ-010 Port: data_tx, output, 1, UART tx line; idles at 1.
REQ-011 Port: ack_in, input, 1, external acknowledgement line; idles at 1.
REQ-012 Port: slave_ready, output, 1, high when a new frame can be accepted.
REQ-013 Port: data_out, output, 8, last byte accepted from the bus.
REQ-014 Port: ack_ok, output, 1, one-cycle pulse when the ack matches.
REQ-015 Port: ack_err, output, 1, one-cycle pulse on ack mismatch or timeout.

Function
REQ-016 The FSM SHALL have the states IDLE, RECV, CHECK, TX_START, TX_DATA, TX_STOP, WAIT_ACK and ACK_RX, all registered; all outputs SHALL be registered.
REQ-017 Frame format: 14 sampled cycles.
- addr_rx carries address bits 13..0, one per sampled cycle.
- data_rx carries data bits 7..0 on sampled cycles 6..13.
- data_rx SHALL be ignored on sampled cycles 0..5.
REQ-018 IDLE→RECV on the first edge with valid_s=1 and slave_ready=1; that edge samples bit 0.
REQ-019 In RECV, valid_s=0 SHALL freeze the shift registers and bit counter without aborting the frame; sampling resumes when valid_s returns to 1 (split transfer).
REQ-020 RECV→CHECK once the 14th bit has been sampled.
REQ-021 In CHECK:
- If address==SLAVE_ADDR and write_en_slave was 1 at bit 0, the FSM SHALL load data_out and the tx shift register and go to TX_START.
- Otherwise it SHALL go to IDLE and data_out SHALL be unchanged.
REQ-022 slave_ready SHALL be 0 from the cycle after the frame start through the return to IDLE, and 1 in IDLE.
REQ-023 TX timing:
- TX_START drives data_tx=0 for 1 cycle.
- TX_DATA drives bits 7..0 MSB first, 1 cycle each.
- TX_STOP drives data_tx=1 for 1 cycle.
- The start bit appears 2 edges after the 14th bit is sampled.
REQ-024 After TX_STOP, the FSM SHALL go to WAIT_ACK and clear the 10-bit timeout counter.
REQ-025 In WAIT_ACK:
- ack_in=0 (start bit) SHALL move the FSM to ACK_RX.
- Otherwise the counter SHALL increment.
- When the counter reaches ACK_TIMEOUT, the block SHALL pulse ack_err and go to IDLE.
REQ-026 ACK_RX SHALL sample 8 bits of ack_in MSB first on the 8 edges following the start bit.
REQ-027 At the end of ACK_RX, the block SHALL pulse ack_ok if the byte equals ACK_PATTERN, otherwise pulse ack_err; it SHALL then go to IDLE.
REQ-028 ack_ok and ack_err SHALL never be high in the same cycle; each SHALL be high for exactly 1 cycle per frame at most.
REQ-029 valid_s asserted while slave_ready=0 SHALL be ignored; frames offered while busy are not captured.

Reset
REQ-030 While reset=1 at a clock edge, the state SHALL go to IDLE and all counters and shift registers SHALL clear.
REQ-031 Reset values: data_tx=1, slave_ready=1, data_out=8'd0, ack_ok=0, ack_err=0.
REQ-032 Reset mid-TX or mid-ACK SHALL return data_tx to 1 on the next edge and SHALL pulse neither ack_ok nor ack_err.

Structure
REQ-033 Package bus_uart_pkg SHALL hold ADDR_W=14, DATA_W=8, DATA_START_BIT=6, the default ACK_PATTERN, the default ACK_TIMEOUT and the state enum.
REQ-034 The block SHALL use one sub-module, uart_byte_tx, which performs the start/8-bit/stop serialisation with load and busy handshakes.

Verification
REQ-035 Frame with addr=14'b01000000000000, data=8'hA5, write_en_slave=1 -> data_tx sequence 0,1,0,1,0,0,1,0,1,1 starting 2 edges after bit 13; data_out=8'hA5.
REQ-036 Frame with addr=14'h0001 -> data_tx stays 1, slave_ready returns to 1, data_out unchanged.
REQ-037 valid_s held low for 5 cycles after bit 8 of a matching frame, data 8'h3C -> frame completes correctly; data_tx carries 8'h3C.
REQ-038 After TX, drive ack_in start bit then 8'b11001100 -> ack_ok pulses 1 cycle; drive 8'b11001101 instead -> ack_err pulses 1 cycle.
REQ-039 No ack after TX -> ack_err 1023 cycles after WAIT_ACK entry, then IDLE.
REQ-040 Reset asserted during TX_DATA bit 4 -> data_tx=1 next edge, slave_ready=1, no ack pulse.
